alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Front-end sequencer that drives the 8-bit ALU from the initiator side of the SEL/A/B/C interface.
- Accepts 19-bit instructions over a valid/ready handshake and decodes them.
- Reads operands from a 4x8 register file, drives alu_sel/alu_a/alu_b, captures alu_c one cycle later, and writes the result back.
- Reports completion, zero flag and error status per instruction.

Parameters:
- DW, 8, datapath width. Only 8 is supported by the 19-bit encoding.
- RA_W, 2, register address width, giving 4 registers. Fixed by the encoding.
- LDI_OP, 5'b10000, opcode for load-immediate.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- instr_in  in  19  instruction: [18:14] op, [13:12] rd, [11:10] rs1, [9:8] rs2, [7:0] imm.
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  block can accept an instruction.
- alu_sel  out  5  ALU opcode (registered).
- alu_a  out  8  ALU operand A (registered).
- alu_b  out  8  ALU operand B (registered).
- alu_c  in  8  ALU combinational result.
- res_valid  out  1  one-cycle completion pulse.
- res_data  out  8  value written, or 0 on error.
- res_rd  out  2  destination register of the completed instruction.
- res_zero  out  1  res_data==0 on a successful write.
- err_div0  out  1  divide by zero; valid with res_valid.
- err_illegal  out  1  unsupported opcode; valid with res_valid.
- dbg_addr  in  2  register file debug read address.
- dbg_data  out  8  combinational read of reg[dbg_addr].

Behaviour:
- Reset (synchronous):
  - All 4 registers = 0; state = IDLE.
  - alu_sel/alu_a/alu_b = 0.
  - res_valid, res_data, res_rd, res_zero, err_* = 0.
  - instr_ready = 0 while RST is high and 1 in the first cycle after reset.
- States:
  - IDLE: instr_ready=1.
  - EXEC: instr_ready=0.
  - DONE: instr_ready=1, res_valid=1.
- Transitions:
  - IDLE, valid&ready -> EXEC.
  - EXEC -> DONE, always.
  - DONE, valid -> EXEC; DONE, no valid -> IDLE.
- Accept edge k: latch op, rd and imm; drive alu_sel/alu_a/alu_b from the decode below.
- Edge k+1:
  - Sample alu_c; write reg[rd] unless in error.
  - Set res_* and state DONE; res_valid is high in the following cycle.
  - Latency from accept to res_valid is 1 cycle.
  - Peak throughput is 1 instruction per 2 cycles.
- Decode (A=reg[rs1], B=reg[rs2]):
  - op 00000-00011 and 01000-01111: pass through with alu_sel=op, alu_a=A, alu_b=B.
  - Unary ops are remapped because the controller never relies on the ALU's internal C feedback (A-only):
    - 00100 INC -> sel 00000, b=1.
    - 00101 DEC -> sel 00001, b=1.
    - 00110 SHL -> sel 00010, b=2.
    - 00111 SHR -> sel 00011, b=2.
    - 01011 NOT -> sel 01010, b=8'hFF.
  - LDI_OP: ALU outputs are held at their previous values; reg[rd]=imm at k+1; res_data=imm.
  - op 10001-11111: err_illegal=1, no register write, res_data=0, ALU outputs held.
  - op 00011 with B==0: err_div0=1, no register write, res_data=0. The alu_c value is ignored.
- Arithmetic: results are truncated to 8 bits by the ALU; the controller adds no saturation. Compare (01111) writes 1 or 0.
- Hazards: an instruction accepted in DONE reads the register file after the k+1 write, so back-to-back dependencies need no stall.
- instr_in is sampled only on the valid&ready edge; changes while ready=0 are ignored.
- Reset mid-EXEC: the instruction is abandoned, no write occurs and no res_valid is produced.
- err_* and res_zero are qualified by res_valid and are 0 whenever res_valid=0.

Test Plan:
- LDI r0=0x05, LDI r1=0x03, ADD r2=r0+r1 -> res_data=0x08, res_rd=2, res_valid 1 cycle after accept, dbg r2=0x08.
- r0=0x0A, r1=0x00, op 00011 r3 -> err_div0=1, res_data=0, r3 unchanged; alu_sel=00011 observed.
- r0=0xFF, INC r1=r0 -> alu_sel=00000, alu_b=1, r1=0x00, res_zero=1. Then NOT r2=r1 -> alu_sel=01010, alu_b=0xFF, r2=0xFF.
- op 10101 -> err_illegal=1, no register change, next instruction accepted normally.
- instr_valid held high with a dependent chain (LDI r0=1, ADD r0=r0+r0 four times) -> accepts every 2 cycles, final r0=0x10.
- Assert RST in the EXEC cycle of ADD -> no res_valid, all registers 0, instr_ready=1 the cycle after RST deasserts.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and per-instruction result bundle between an issuer
// (master) and the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int DW   = 8,
    parameter int RA_W = 2
);
    localparam int IW = 5 + 3 * RA_W + DW;

    logic [IW-1:0]   instr_in;
    logic            instr_valid;
    logic            instr_ready;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [RA_W-1:0] res_rd;
    logic            res_zero;
    logic            err_div0;
    logic            err_illegal;

    modport master (
        output instr_in, instr_valid,
        input  instr_ready, res_valid, res_data, res_rd, res_zero,
               err_div0, err_illegal
    );

    modport slave (
        input  instr_in, instr_valid,
        output instr_ready, res_valid, res_data, res_rd, res_zero,
               err_div0, err_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Front-end sequencer for the 8-bit ALU: decodes instructions, reads a 4x8
// register file, drives the ALU operands, captures the result one cycle later
// and writes it back, reporting completion and error status per instruction.
module alu_issue_ctrl #(
    parameter int         DW     = 8,
    parameter int         RA_W   = 2,
    parameter logic [4:0] LDI_OP = 5'b10000
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus,
    output logic [4:0]      alu_sel,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    input  logic [DW-1:0]   alu_c,
    input  logic [RA_W-1:0] dbg_addr,
    output logic [DW-1:0]   dbg_data
);

    localparam int NREG = 2 ** RA_W;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state;
    logic [DW-1:0]   regs [NREG];

    // Fields of the instruction currently offered on the bus
    logic [4:0]      op;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   opnd_a;
    logic [DW-1:0]   opnd_b;
    logic            accept;

    // Decode results
    logic [4:0]      dec_sel;
    logic [DW-1:0]   dec_b;
    logic            dec_drive;
    logic            dec_ldi;
    logic            dec_illegal;
    logic            dec_div0;

    // State captured at the accept edge for use at the completion edge
    logic [RA_W-1:0] rd_q;
    logic [DW-1:0]   imm_q;
    logic            ldi_q;
    logic            illegal_q;
    logic            div0_q;

    // Registered result outputs
    logic            res_valid_q;
    logic [DW-1:0]   res_data_q;
    logic [RA_W-1:0] res_rd_q;
    logic            res_zero_q;
    logic            err_div0_q;
    logic            err_illegal_q;

    assign op     = bus.instr_in[5+3*RA_W+DW-1 -: 5];
    assign rd     = bus.instr_in[3*RA_W+DW-1 -: RA_W];
    assign rs1    = bus.instr_in[2*RA_W+DW-1 -: RA_W];
    assign rs2    = bus.instr_in[RA_W+DW-1 -: RA_W];
    assign imm    = bus.instr_in[DW-1:0];
    assign opnd_a = regs[rs1];
    assign opnd_b = regs[rs2];

    // Ready is forced low during reset so nothing is accepted on a reset edge
    assign bus.instr_ready = !rst && (state != EXEC);
    assign accept          = bus.instr_valid && bus.instr_ready;

    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.err_div0    = err_div0_q;
    assign bus.err_illegal = err_illegal_q;

    assign dbg_data = regs[dbg_addr];

    // Map opcodes onto ALU selects; unary ops become binary ops with a constant B
    always_comb begin
        dec_sel     = op;
        dec_b       = opnd_b;
        dec_drive   = 1'b1;
        dec_ldi     = 1'b0;
        dec_illegal = 1'b0;
        dec_div0    = 1'b0;
        if (op == LDI_OP) begin
            dec_ldi   = 1'b1;
            dec_drive = 1'b0;
        end else if (op[4]) begin
            dec_illegal = 1'b1;
            dec_drive   = 1'b0;
        end else begin
            case (op)
                5'b00011: dec_div0 = (opnd_b == '0);
                5'b00100: begin dec_sel = 5'b00000; dec_b = DW'(1); end
                5'b00101: begin dec_sel = 5'b00001; dec_b = DW'(1); end
                5'b00110: begin dec_sel = 5'b00010; dec_b = DW'(2); end
                5'b00111: begin dec_sel = 5'b00011; dec_b = DW'(2); end
                5'b01011: begin dec_sel = 5'b01010; dec_b = '1;     end
                default:  ;
            endcase
        end
    end

    // Sequencer: accept in IDLE/DONE, complete and write back on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            alu_sel       <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            ldi_q         <= 1'b0;
            illegal_q     <= 1'b0;
            div0_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_zero_q    <= 1'b0;
            err_div0_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            res_valid_q   <= 1'b0;
            res_zero_q    <= 1'b0;
            err_div0_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            case (state)
                EXEC: begin
                    res_valid_q <= 1'b1;
                    res_rd_q    <= rd_q;
                    if (illegal_q) begin
                        err_illegal_q <= 1'b1;
                        res_data_q    <= '0;
                    end else if (div0_q) begin
                        err_div0_q <= 1'b1;
                        res_data_q <= '0;
                    end else if (ldi_q) begin
                        regs[rd_q] <= imm_q;
                        res_data_q <= imm_q;
                        res_zero_q <= (imm_q == '0);
                    end else begin
                        regs[rd_q] <= alu_c;
                        res_data_q <= alu_c;
                        res_zero_q <= (alu_c == '0);
                    end
                    state <= DONE;
                end
                default: begin
                    if (accept) begin
                        rd_q      <= rd;
                        imm_q     <= imm;
                        ldi_q     <= dec_ldi;
                        illegal_q <= dec_illegal;
                        div0_q    <= dec_div0;
                        if (dec_drive) begin
                            alu_sel <= dec_sel;
                            alu_a   <= opnd_a;
                            alu_b   <= dec_b;
                        end
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random
// instruction streams, with results compared by a scoreboard monitor.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] alu_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_c;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] rd;
        logic       zero;
        logic       div0;
        logic       ill;
        logic [4:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        int         acceptCycle;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mreg [4];
    logic [4:0] lastSel;
    logic [7:0] lastA;
    logic [7:0] lastB;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_sel  (alu_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_c    (alu_c),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural 8-bit ALU seen by the controller
    always_comb begin
        case (alu_sel)
            5'd0:    alu_c = alu_a + alu_b;
            5'd1:    alu_c = alu_a - alu_b;
            5'd2:    alu_c = alu_a * alu_b;
            5'd3:    alu_c = (alu_b == 8'd0) ? 8'hEE : alu_a / alu_b;
            5'd8:    alu_c = alu_a & alu_b;
            5'd9:    alu_c = alu_a | alu_b;
            5'd10:   alu_c = alu_a ^ alu_b;
            5'd12:   alu_c = ~(alu_a & alu_b);
            5'd13:   alu_c = ~(alu_a | alu_b);
            5'd14:   alu_c = ~(alu_a ^ alu_b);
            5'd15:   alu_c = (alu_a < alu_b) ? 8'd1 : 8'd0;
            default: alu_c = 8'hA5;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        lastSel = 5'd0;
        lastA   = 8'h00;
        lastB   = 8'h00;
    endtask

    // Reference: instruction semantics from the opcode meaning, in plain arithmetic
    task automatic modelExec(input int op, input int rd, input int rs1, input int rs2,
                             input int imm, output exp_t e);
        int  a;
        int  b;
        int  r;
        bit  drive;
        int  sel;
        int  bDrv;
        a = int'(mreg[rs1]);
        b = int'(mreg[rs2]);
        r = 0;
        e.div0 = 1'b0;
        e.ill  = 1'b0;
        drive  = (op < 16);
        sel    = op;
        bDrv   = b;
        case (op)
            0:  r = (a + b) % 256;
            1:  r = (a - b + 256) % 256;
            2:  r = (a * b) % 256;
            3:  if (b == 0) e.div0 = 1'b1; else r = a / b;
            4:  begin r = (a + 1) % 256;   sel = 0;  bDrv = 1;   end
            5:  begin r = (a + 255) % 256; sel = 1;  bDrv = 1;   end
            6:  begin r = (a * 2) % 256;   sel = 2;  bDrv = 2;   end
            7:  begin r = a / 2;           sel = 3;  bDrv = 2;   end
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: begin r = 255 - a;         sel = 10; bDrv = 255; end
            12: r = 255 - (a & b);
            13: r = 255 - (a | b);
            14: r = 255 - (a ^ b);
            15: r = (a < b) ? 1 : 0;
            16: r = imm;
            default: e.ill = 1'b1;
        endcase
        if (drive) begin
            lastSel = 5'(sel);
            lastA   = 8'(a);
            lastB   = 8'(bDrv);
        end
        e.rd   = 2'(rd);
        e.data = (e.div0 || e.ill) ? 8'h00 : 8'(r);
        e.zero = !e.div0 && !e.ill && (e.data == 8'h00);
        e.sel  = lastSel;
        e.a    = lastA;
        e.b    = lastB;
        if (!e.div0 && !e.ill) mreg[rd] = e.data;
    endtask

    // Offer one instruction and wait (bounded) for it to be accepted
    task automatic applyStimulus(input int op, input int rd, input int rs1, input int rs2,
                                 input int imm, input bit keepValid, input bit track,
                                 output int accCycle);
        exp_t e;
        int   waitCnt;
        @(negedge clk);
        bus.instr_in    = {5'(op), 2'(rd), 2'(rs1), 2'(rs2), 8'(imm)};
        bus.instr_valid = 1'b1;
        waitCnt = 0;
        while (!bus.instr_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.instr_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            accCycle = -1;
            return;
        end
        @(posedge clk);
        #1;
        accCycle = cycle;
        if (track) begin
            modelExec(op, rd, rs1, rs2, imm, e);
            e.acceptCycle = cycle;
            sbq.push_back(e);
        end
        if (!keepValid) begin
            bus.instr_valid = 1'b0;
            bus.instr_in    = 19'($urandom);
        end
    endtask

    task automatic drainWait();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic checkRegs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checkOutput($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(mreg[i]));
        end
    endtask

    // Monitor: every completion is popped from the scoreboard and compared
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.res_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_res_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("res_data",    32'(bus.res_data),    32'(e.data));
                    checkOutput("res_rd",      32'(bus.res_rd),      32'(e.rd));
                    checkOutput("res_zero",    32'(bus.res_zero),    32'(e.zero));
                    checkOutput("err_div0",    32'(bus.err_div0),    32'(e.div0));
                    checkOutput("err_illegal", 32'(bus.err_illegal), 32'(e.ill));
                    checkOutput("alu_sel",     32'(alu_sel),         32'(e.sel));
                    checkOutput("alu_a",       32'(alu_a),           32'(e.a));
                    checkOutput("alu_b",       32'(alu_b),           32'(e.b));
                    checkOutput("latency",     32'(cycle - e.acceptCycle), 32'd1);
                end
            end else begin
                checkOutput("flags_without_valid",
                            32'({bus.err_div0, bus.err_illegal, bus.res_zero}), 32'd0);
            end
        end
    end

    // Hard stop in case something stalls beyond every bounded wait
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        int acc;
        int accPrev;
        int op;
        bus.instr_in    = '0;
        bus.instr_valid = 1'b0;
        dbg_addr        = 2'd0;
        resetModel();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("ready_in_reset",     32'(bus.instr_ready), 32'd0);
        checkOutput("reset_alu_sel",      32'(alu_sel),         32'd0);
        checkOutput("reset_alu_a",        32'(alu_a),           32'd0);
        checkOutput("reset_alu_b",        32'(alu_b),           32'd0);
        checkOutput("reset_res_valid",    32'(bus.res_valid),   32'd0);
        checkRegs("reset");
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset",  32'(bus.instr_ready), 32'd1);

        // LDI/LDI/ADD
        applyStimulus(16, 0, 0, 0, 8'h05, 1'b0, 1'b1, acc);
        applyStimulus(16, 1, 0, 0, 8'h03, 1'b0, 1'b1, acc);
        applyStimulus(0,  2, 0, 1, 8'h00, 1'b0, 1'b1, acc);
        drainWait();
        checkRegs("add");

        // Divide by zero leaves r3 untouched
        applyStimulus(16, 0, 0, 0, 8'h0A, 1'b0, 1'b1, acc);
        applyStimulus(16, 1, 0, 0, 8'h00, 1'b0, 1'b1, acc);
        applyStimulus(3,  3, 0, 1, 8'h00, 1'b0, 1'b1, acc);
        drainWait();
        checkRegs("div0");

        // INC wraps to zero, then NOT
        applyStimulus(16, 0, 0, 0, 8'hFF, 1'b0, 1'b1, acc);
        applyStimulus(4,  1, 0, 0, 8'h00, 1'b0, 1'b1, acc);
        applyStimulus(11, 2, 1, 0, 8'h00, 1'b0, 1'b1, acc);
        drainWait();
        checkRegs("incnot");

        // Illegal opcode followed by a normal instruction
        applyStimulus(21, 2, 0, 1, 8'h77, 1'b0, 1'b1, acc);
        applyStimulus(16, 3, 0, 0, 8'h42, 1'b0, 1'b1, acc);
        drainWait();
        checkRegs("illegal");

        // Dependent chain with valid held high
        applyStimulus(16, 0, 0, 0, 8'h01, 1'b1, 1'b1, accPrev);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, (i != 3), 1'b1, acc);
            checkOutput($sformatf("chain_gap%0d", i), 32'(acc - accPrev), 32'd2);
            accPrev = acc;
        end
        drainWait();
        checkRegs("chain");

        // Reset during EXEC abandons the instruction
        applyStimulus(16, 1, 0, 0, 8'h07, 1'b0, 1'b1, acc);
        drainWait();
        applyStimulus(0, 2, 1, 1, 8'h00, 1'b0, 1'b0, acc);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_during_rst", 32'(bus.instr_ready), 32'd0);
        checkOutput("no_res_valid_rst", 32'(bus.res_valid),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        #1;
        checkOutput("ready_after_rst",  32'(bus.instr_ready), 32'd1);
        checkOutput("alu_sel_after_rst", 32'(alu_sel),        32'd0);
        checkRegs("midexec_rst");

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 2) == 0) ? 16 : int'($urandom_range(0, 31));
            applyStimulus(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                          bit'($urandom_range(0, 1)), 1'b1, acc);
            if ($urandom_range(0, 3) == 0) begin
                bus.instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.instr_valid = 1'b0;
        drainWait();
        checkRegs("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
